alu_issue_scheduler: RTL
========================

Name: alu_issue_scheduler

Overview:
Shares the single integer ALU between NUM_REQ reservation-station requesters. It arbitrates round-robin and issues one op at a time. It sequences long-latency ops (DIV/DIVU/REM/REMU and their W forms) over LONG_LAT cycles, and holds the result until the common data bus accepts it. The operand and op muxes outside this block use issue_idx; the scheduler owns only grant, timing and result tagging.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TAG_W, 6, width of ROB tag carried with each op
LONG_LAT, 8, issue-to-result latency in cycles for long ops (>= 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  requester i has a ready op
req_long  in  NUM_REQ  op of requester i is long-latency (divide/remainder)
req_tag  in  NUM_REQ*TAG_W  ROB tag of requester i, slice i at [i*TAG_W +: TAG_W]
flush  in  1  mispredict flush; kills any in-flight op
grant  out  NUM_REQ  one-hot issue grant (combinational)
issue_valid  out  1  an op is issued this cycle (= |grant)
issue_idx  out  $clog2(NUM_REQ)  index of the granted requester (0 when none)
res_valid  out  1  result available for the CDB
res_tag  out  TAG_W  ROB tag of the result
res_ready  in  1  CDB accepts the result this cycle
busy  out  1  state != IDLE

Behaviour:
- Asynchronous reset: state=IDLE, rr_ptr=0, cnt=0, res_valid=0, res_tag=0, busy=0. grant=0 while reset is asserted.
- States:
  - IDLE: nothing in flight.
  - EXEC: long op counting down.
  - RESULT: res_valid=1, waiting for res_ready.
- can_issue = !flush && (state==IDLE || (state==RESULT && res_ready)).
- Arbitration:
  - When can_issue, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At most one grant bit is set. Grant is combinational. A requester that sees grant[i]=1 with req_valid[i]=1 considers its op issued at that clock edge.
  - On issue, rr_ptr <= (i+1) mod NUM_REQ. Without an issue, rr_ptr holds.
- Issue of a short op (req_long[i]=0):
  - Next state RESULT, res_tag <= tag i.
  - res_valid is high in the cycle after issue (latency 1).
- Issue of a long op:
  - Next state EXEC, cnt <= LONG_LAT-1, res_tag <= tag i.
- EXEC:
  - cnt decrements each cycle.
  - When cnt==1, next state RESULT.
  - res_valid first rises exactly LONG_LAT cycles after the issue edge.
  - No grants are made during EXEC.
- RESULT:
  - res_valid and res_tag are held stable until res_ready=1.
  - On res_ready with no new issue, next state IDLE.
  - On res_ready with a same-cycle issue, go to RESULT (short) or EXEC (long), giving back-to-back short ops a throughput of 1/cycle.
- flush:
  - Takes priority over everything; no grant is made in a flush cycle.
  - Next state IDLE, res_valid <= 0, cnt <= 0. rr_ptr is unchanged.
  - A result presented with res_ready=1 in the flush cycle is still considered consumed by the CDB.
- req_valid deasserting without a grant is legal; the scheduler keeps no request state.
- Requests arriving during EXEC or a stalled RESULT wait; no starvation. Every requester is granted within NUM_REQ issues of first asserting valid.
- Reset mid-operation drops everything immediately (asynchronous).

Test Plan:
- Reset/idle: assert reset mid-EXEC -> busy=0, res_valid=0, grant=0 immediately; after release with req_valid=0, outputs stay 0.
- Round-robin, NUM_REQ=4: req_valid=4'b1111, all short, res_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. res_tag in each following cycle matches the granted slice.
- Long latency, LONG_LAT=8: issue req 2 long with tag 0x15 at cycle 0 -> busy from cycle 1, no grants in cycles 1-7, res_valid=1 with res_tag=0x15 first at cycle 8.
- CDB stall: short op issued, res_ready=0 for 3 cycles with other requests pending -> res_valid/res_tag held, grant=0. In the cycle res_ready=1, the next requester is granted and its result appears the following cycle.
- Flush: flush during EXEC with cnt=4 and req_valid=4'b0001 -> no grant that cycle, state IDLE next cycle, res_valid never asserts for the killed tag, rr_ptr unchanged. Requester 0 is granted the cycle after flush drops.
- Fairness: req 0 asserted continuously, req 3 asserted once -> req 3 is granted within 4 issues.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler for the shared integer ALU: grants one requester
// per issue, times short and long ops, and holds the tagged result for the CDB.
module alu_issue_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_W    = 6,
    parameter int LONG_LAT = 8,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(LONG_LAT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_long,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     issue_valid,
    output logic [IDX_W-1:0]         issue_idx,
    output logic                     res_valid,
    output logic [TAG_W-1:0]         res_tag,
    input  logic                     res_ready,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [TAG_W-1:0]   res_tag_q;
    logic               res_valid_q;
    logic               busy_q;
    logic               can_issue;
    logic               issue_long;
    logic [TAG_W-1:0]   issue_tag;

    // A free slot exists when idle, or when the held result leaves this cycle.
    always_comb begin
        can_issue   = !reset && !flush &&
                      (state_q == IDLE || (state_q == RESULT && res_ready));
        grant       = '0;
        issue_valid = 1'b0;
        issue_idx   = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!issue_valid && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                    issue_valid = 1'b1;
                    issue_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                end
            end
        end
        if (issue_valid) begin
            grant[issue_idx] = 1'b1;
        end
    end

    assign issue_long = req_long[issue_idx];
    assign issue_tag  = req_tag[issue_idx*TAG_W +: TAG_W];
    assign rr_ptr_d   = (issue_idx == IDX_W'(NUM_REQ-1)) ? '0 : issue_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            res_tag_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            // The round-robin pointer survives a flush so fairness is preserved.
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (issue_valid) begin
            rr_ptr_q  <= rr_ptr_d;
            res_tag_q <= issue_tag;
            busy_q    <= 1'b1;
            if (issue_long) begin
                state_q     <= EXEC;
                cnt_q       <= CNT_W'(LONG_LAT-1);
                res_valid_q <= 1'b0;
            end else begin
                state_q     <= RESULT;
                res_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                EXEC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign busy      = busy_q;

endmodule
